// File: rtl/twiddle_cmult_pipe_pkg.sv
// Shared definitions for the twiddle complex-multiplier pipeline.
// Default widths, rounding-mode encodings and two's complement saturation limits.
// No logic; imported by the pipeline top and its quantiser.
package twiddle_cmult_pipe_pkg;

  localparam int DEF_W     = 16;
  localparam int DEF_FRAC  = 15;
  localparam int DEF_TAG_W = 8;

  // Rounding modes of the output quantiser
  localparam int RND_TRUNC   = 0;  // floor
  localparam int RND_HALF_UP = 1;  // add half an LSB before the shift

  // Largest value of an n-bit two's complement number, in a wide signed container
  function automatic logic signed [127:0] sat_hi(input int n);
    return (128'sd1 <<< (n - 1)) - 128'sd1;
  endfunction

  // Smallest value of an n-bit two's complement number, in a wide signed container
  function automatic logic signed [127:0] sat_lo(input int n);
    return -(128'sd1 <<< (n - 1));
  endfunction

endpackage

// File: rtl/twiddle_cmult_pipe_round_sat.sv
// Quantiser: optional half-up rounding, arithmetic shift by FRAC, clamp to W bits.
// Latency: combinational.
// Backpressure: none; ovf_o flags that the clamp was applied.
module twiddle_cmult_pipe_round_sat
  import twiddle_cmult_pipe_pkg::*;
#(
  parameter int IN_W = 2 * DEF_W + 3,
  parameter int FRAC = DEF_FRAC,
  parameter int W    = DEF_W,
  parameter int RND  = RND_HALF_UP
) (
  input  logic signed [IN_W-1:0] din_i,
  output logic signed [W-1:0]    dout_o,
  output logic                   ovf_o
);

  // One guard bit so the rounding add can never wrap
  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] HALF =
    (RND == RND_HALF_UP && FRAC > 0) ? (EXT_W'(1) <<< ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(sat_hi(W));
  localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(sat_lo(W));

  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;

  // Round, shift down to the output scale, then clamp into the W-bit range
  always_comb begin
    biased  = EXT_W'(din_i) + HALF;
    shifted = biased >>> FRAC;
    ovf_o   = (shifted > SAT_HI) || (shifted < SAT_LO);
    if (shifted > SAT_HI) begin
      dout_o = W'(SAT_HI);
    end else if (shifted < SAT_LO) begin
      dout_o = W'(SAT_LO);
    end else begin
      dout_o = shifted[W-1:0];
    end
  end

endmodule

// File: rtl/twiddle_cmult_pipe.sv
// Pipelined complex multiply y = b*w or b*conj(w), Gauss 3-multiplier form, saturating.
// Latency: 4 register stages; accepted at edge N, presented after edge N+3.
// Backpressure: whole pipe stalls when the output is held; in_ready = out_ready | ~out_valid.
module twiddle_cmult_pipe
  import twiddle_cmult_pipe_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int FRAC  = DEF_FRAC,
  parameter int RND   = RND_HALF_UP,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_conj,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic signed [W-1:0]     br,
  input  logic signed [W-1:0]     bi,
  input  logic signed [W-1:0]     wr,
  input  logic signed [W-1:0]     wi,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W-1:0]     yr,
  output logic signed [W-1:0]     yi,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int SW_W = W + 1;      // pre-add sums
  localparam int PQ_W = 2 * W;      // q and r products
  localparam int P_W  = 2 * W + 2;  // p product
  localparam int R_W  = 2 * W + 3;  // post-add results
  localparam logic signed [W-1:0] W_MIN = W'(sat_lo(W));
  localparam logic signed [W-1:0] W_MAX = W'(sat_hi(W));

  logic adv;

  // Stage valid bits
  logic v1_q, v2_q, v3_q, v4_q;

  // S1: captured operands and pre-adds
  logic signed [W-1:0]    wi_eff_d;
  logic signed [SW_W-1:0] sb_d, sw_d;
  logic signed [W-1:0]    br1_q, bi1_q, wr1_q, wi1_q;
  logic signed [SW_W-1:0] sb1_q, sw1_q;
  logic [TAG_W-1:0]       tag1_q;

  // S2: products
  logic signed [PQ_W-1:0] q_d, r_d, q2_q, r2_q;
  logic signed [P_W-1:0]  p_d, p2_q;
  logic [TAG_W-1:0]       tag2_q;

  // S3: post-adds
  logic signed [R_W-1:0]  re_d, im_d, re3_q, im3_q;
  logic [TAG_W-1:0]       tag3_q;

  // S4: quantised outputs and sticky overflow
  logic signed [W-1:0]    yr_d, yi_d, yr_q, yi_q;
  logic [TAG_W-1:0]       tag4_q;
  logic                   ovf_re, ovf_im;
  logic                   ovf_d, ovf_q;

  // A held output freezes every stage; bubbles ride along as valid = 0
  assign adv      = out_ready | ~v4_q;
  assign in_ready = adv;

  // Conjugate the twiddle (negating the most negative value clamps without flagging ovf) and form pre-adds
  always_comb begin
    wi_eff_d = wi;
    if (in_conj) begin
      wi_eff_d = (wi == W_MIN) ? W_MAX : -wi;
    end
    sb_d = SW_W'(br) + SW_W'(bi);
    sw_d = SW_W'(wr) + SW_W'(wi_eff_d);
  end

  // Three full-precision products
  always_comb begin
    q_d = PQ_W'(br1_q) * PQ_W'(wr1_q);
    r_d = PQ_W'(bi1_q) * PQ_W'(wi1_q);
    p_d = P_W'(sb1_q) * P_W'(sw1_q);
  end

  // Gauss post-adds: Re = q - r, Im = p - q - r
  always_comb begin
    re_d = R_W'(q2_q) - R_W'(r2_q);
    im_d = R_W'(p2_q) - R_W'(q2_q) - R_W'(r2_q);
  end

  twiddle_cmult_pipe_round_sat #(
    .IN_W (R_W),
    .FRAC (FRAC),
    .W    (W),
    .RND  (RND)
  ) u_rs_re (
    .din_i  (re3_q),
    .dout_o (yr_d),
    .ovf_o  (ovf_re)
  );

  twiddle_cmult_pipe_round_sat #(
    .IN_W (R_W),
    .FRAC (FRAC),
    .W    (W),
    .RND  (RND)
  ) u_rs_im (
    .din_i  (im3_q),
    .dout_o (yi_d),
    .ovf_o  (ovf_im)
  );

  // Sticky overflow: set only when a valid sample clamps as it loads S4; set beats clear
  always_comb begin
    ovf_d = (ovf_q & ~ovf_clr) | (adv & v3_q & (ovf_re | ovf_im));
  end

  // Valid bits, output stage and overflow flag; reset discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      v4_q   <= 1'b0;
      yr_q   <= '0;
      yi_q   <= '0;
      tag4_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (adv) begin
        v1_q   <= in_valid;
        v2_q   <= v1_q;
        v3_q   <= v2_q;
        v4_q   <= v3_q;
        yr_q   <= yr_d;
        yi_q   <= yi_d;
        tag4_q <= tag3_q;
      end
    end
  end

  // Datapath stages S1..S3; contents are only meaningful alongside their valid bit
  always_ff @(posedge clk) begin
    if (adv) begin
      br1_q  <= br;
      bi1_q  <= bi;
      wr1_q  <= wr;
      wi1_q  <= wi_eff_d;
      sb1_q  <= sb_d;
      sw1_q  <= sw_d;
      tag1_q <= in_tag;
      q2_q   <= q_d;
      r2_q   <= r_d;
      p2_q   <= p_d;
      tag2_q <= tag1_q;
      re3_q  <= re_d;
      im3_q  <= im_d;
      tag3_q <= tag2_q;
    end
  end

  assign out_valid = v4_q;
  assign yr        = yr_q;
  assign yi        = yi_q;
  assign out_tag   = tag4_q;
  assign ovf       = ovf_q;

endmodule
